// File: rtl/ir_pkg.sv
// Shared widths, default tuning values and handshake states for the IR line detector.
package ir_pkg;
  localparam int IR_COUNT_W  = 19;
  localparam int E100_WORD_W = 32;
  localparam int SUM_W       = 21;

  localparam logic [IR_COUNT_W-1:0] SAMPLE_PERIOD_DEF = 19'd310000;
  localparam logic [IR_COUNT_W-1:0] THRESH_HI_DEF     = 19'd2000;
  localparam logic [IR_COUNT_W-1:0] THRESH_LO_DEF     = 19'd1500;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    RESPOND
  } hs_state_e;
endpackage

// File: rtl/ir_line_detect_if.sv
// E100 I/O request/acknowledge bus between the processor side and the IR line detector.
interface ir_line_detect_if;
  import ir_pkg::*;

  logic                   ir_command;
  logic                   ir_response;
  logic [E100_WORD_W-1:0] ir_data;

  modport master (output ir_command, input ir_response, input ir_data);
  modport slave  (input ir_command, output ir_response, output ir_data);
endinterface

// File: rtl/ir_line_detect_sync.sv
// Two-flop synchronizer; enable qualifies every update, including reset.
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (enable) begin
      if (reset) begin
        meta <= '0;
        q    <= '0;
      end else begin
        meta <= d;
        q    <= meta;
      end
    end
  end
endmodule

// File: rtl/ir_line_detect.sv
// IR line detector: periodic 4-sample moving average, threshold flag, E100 read handshake.
// Define IR_LINE_HYST_EN to enable hysteresis between THRESH_LO and THRESH_HI.
module ir_line_detect
  import ir_pkg::*;
#(
  parameter logic [IR_COUNT_W-1:0] SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
  parameter logic [IR_COUNT_W-1:0] THRESH_HI     = THRESH_HI_DEF,
  parameter logic [IR_COUNT_W-1:0] THRESH_LO     = THRESH_LO_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clock_valid,
  input  logic [IR_COUNT_W-1:0] ir_count,
  ir_line_detect_if.slave       e100,
  output logic                  line_detected
);

  if (THRESH_LO > THRESH_HI) begin : g_bad_thresh
    $error("THRESH_LO must not exceed THRESH_HI");
  end

  function automatic logic [IR_COUNT_W-1:0] avg_of(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:2];
  endfunction

`ifdef IR_LINE_HYST_EN
  function automatic logic detect(input logic primed_n, input logic flag_now,
                                  input logic [IR_COUNT_W-1:0] avg_n);
    if (!primed_n) return 1'b0;
    if (flag_now)  return !(avg_n < THRESH_LO);
    return avg_n >= THRESH_HI;
  endfunction
`else
  function automatic logic detect(input logic primed_n, input logic [IR_COUNT_W-1:0] avg_n);
    return primed_n && (avg_n >= THRESH_HI);
  endfunction
`endif

  logic [IR_COUNT_W-1:0] timer;
  logic [IR_COUNT_W-1:0] win [4];
  logic [SUM_W-1:0]      sum_p1;
  logic [IR_COUNT_W-1:0] avg_p1;
  logic [1:0]            fill_cnt;
  logic                  primed;
  logic                  command_sync;
  hs_state_e             state;

  logic                  vld_p0;
  logic [SUM_W-1:0]      sum_next;
  logic [IR_COUNT_W-1:0] avg_next;
  logic                  primed_next;
  logic                  flag_next;

  // p0: sample strobe on timer wrap, running-sum update
  always_comb begin
    vld_p0      = (timer == SAMPLE_PERIOD - 1'b1);
    sum_next    = sum_p1 + SUM_W'(ir_count) - SUM_W'(win[3]);
    avg_next    = avg_of(sum_next);
    primed_next = primed || (fill_cnt == 2'd3);
`ifdef IR_LINE_HYST_EN
    flag_next   = detect(primed_next, line_detected, avg_next);
`else
    flag_next   = detect(primed_next, avg_next);
`endif
  end

  // p1: window, sum, average and detection flag registers
  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (reset) begin
        timer         <= '0;
        win           <= '{default: '0};
        sum_p1        <= '0;
        avg_p1        <= '0;
        fill_cnt      <= '0;
        primed        <= 1'b0;
        line_detected <= 1'b0;
      end else begin
        timer <= vld_p0 ? '0 : timer + 1'b1;
        if (vld_p0) begin
          win[0]        <= ir_count;
          win[1]        <= win[0];
          win[2]        <= win[1];
          win[3]        <= win[2];
          sum_p1        <= sum_next;
          avg_p1        <= avg_next;
          primed        <= primed_next;
          line_detected <= flag_next;
          if (!primed) fill_cnt <= fill_cnt + 1'b1;
        end
      end
    end
  end

  synchronizer #(.WIDTH(1)) u_cmd_sync (
    .clock  (clock),
    .reset  (reset),
    .enable (clock_valid),
    .d      (e100.ir_command),
    .q      (command_sync)
  );

  // Handshake: LATCH reads the registered flag/avg, so a coincident sample is not seen
  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (reset) begin
        state            <= IDLE;
        e100.ir_data     <= '0;
        e100.ir_response <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            e100.ir_response <= 1'b0;
            if (command_sync) state <= LATCH;
          end
          LATCH: begin
            e100.ir_data     <= {line_detected, 12'b0, avg_p1};
            e100.ir_response <= 1'b1;
            state            <= RESPOND;
          end
          RESPOND: begin
            if (!command_sync) begin
              e100.ir_response <= 1'b0;
              state            <= IDLE;
            end
          end
          default: begin
            e100.ir_response <= 1'b0;
            state            <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_line_detect.sv
// Directed bench for ir_line_detect with a short sample period; expectations are hand-computed.
module tb_ir_line_detect;
  import ir_pkg::*;

  localparam logic [IR_COUNT_W-1:0] P = 19'd16;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  clock_valid;
  logic [IR_COUNT_W-1:0] ir_count;
  logic                  line_detected;

  ir_line_detect_if bus ();

  ir_line_detect #(
    .SAMPLE_PERIOD (P),
    .THRESH_HI     (19'd2000),
    .THRESH_LO     (19'd1500)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .clock_valid   (clock_valid),
    .ir_count      (ir_count),
    .e100          (bus),
    .line_detected (line_detected)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int phase   = 0;

`ifdef IR_LINE_HYST_EN
  int exp_1800 [4] = '{1, 1, 1, 1};
  int exp_1400 [4] = '{1, 1, 1, 0};
`else
  int exp_1800 [4] = '{1, 1, 0, 0};
  int exp_1400 [4] = '{0, 0, 0, 0};
`endif
  int exp_2000 [4] = '{0, 0, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle; phase mirrors the sample timer position.
  task automatic tick();
    @(posedge clock);
    #1;
    if (clock_valid) begin
      if (reset) phase = 0;
      else phase = (phase + 1) % int'(P);
    end
  endtask

  task automatic next_sample(input logic [IR_COUNT_W-1:0] val);
    ir_count = val;
    do tick(); while (phase != 0);
  endtask

  task automatic wait_fall(input string tag);
    int lat;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.ir_response === 1'b0) begin
        lat = i;
        break;
      end
    end
    check(tag, lat, 3);
  endtask

  task automatic check_read(input string tag, input logic [31:0] exp_word);
    int          lat;
    logic [31:0] w;
    lat = 99;
    bus.ir_command = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.ir_response === 1'b1) begin
        lat = i;
        break;
      end
    end
    w = bus.ir_data;
    check({tag, "_rise_lat"}, lat, 4);
    check({tag, "_data"}, w, exp_word);
    bus.ir_command = 1'b0;
    wait_fall({tag, "_fall_lat"});
  endtask

  initial begin
    reset          = 1'b1;
    clock_valid    = 1'b1;
    ir_count       = '0;
    bus.ir_command = 1'b0;
    tick();
    tick();
    check("reset_response", bus.ir_response, 0);
    check("reset_data", bus.ir_data, 0);
    check("reset_flag", line_detected, 0);
    reset = 1'b0;

    // Priming with a steady 2500
    for (int i = 0; i < 4; i++) begin
      next_sample(19'd2500);
      check($sformatf("prime_2500_s%0d", i), line_detected, (i == 3));
    end
    check_read("steady_2500", {1'b1, 12'b0, 19'd2500});

    // Averages 2325, 2150, 1975, 1800
    for (int i = 0; i < 4; i++) begin
      next_sample(19'd1800);
      check($sformatf("step_1800_s%0d", i), line_detected, exp_1800[i]);
    end
    check_read("avg_1800", {(exp_1800[3] != 0), 12'b0, 19'd1800});

    // Averages 1700, 1600, 1500 (low-threshold boundary), 1400
    for (int i = 0; i < 4; i++) begin
      next_sample(19'd1400);
      check($sformatf("step_1400_s%0d", i), line_detected, exp_1400[i]);
    end

    // Averages 1550, 1700, 1850, 2000 (high-threshold boundary sets)
    for (int i = 0; i < 4; i++) begin
      next_sample(19'd2000);
      check($sformatf("step_2000_s%0d", i), line_detected, exp_2000[i]);
    end
    check_read("avg_2000", {1'b1, 12'b0, 19'd2000});

    // Unprimed: avg tracks but flag stays low; full-scale window
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_flag", line_detected, 0);
    check("rst2_data", bus.ir_data, 0);
    next_sample(19'd300000);
    check("unprimed_flag_s0", line_detected, 0);
    check_read("unprimed_avg", {1'b0, 12'b0, 19'd75000});
    next_sample(19'd300000);
    next_sample(19'd300000);
    check("unprimed_flag_s2", line_detected, 0);
    next_sample(19'd300000);
    check("full_scale_flag", line_detected, 1);
    check_read("full_scale_avg", {1'b1, 12'b0, 19'd300000});

    // Samples 0, 0, 0, 300000
    reset = 1'b1;
    tick();
    reset = 1'b0;
    next_sample(19'd0);
    next_sample(19'd0);
    next_sample(19'd0);
    check("zeros_flag", line_detected, 0);
    next_sample(19'd300000);
    check("spike_flag", line_detected, 1);
    check_read("spike_avg", {1'b1, 12'b0, 19'd75000});

    // LATCH on the same edge as a sample update keeps the old average
    ir_count = 19'd1000;
    for (int i = 0; i < 2 * int'(P) && phase != int'(P) - 4; i++) tick();
    bus.ir_command = 1'b1;
    repeat (4) tick();
    check("coinc_response", bus.ir_response, 1);
    check("coinc_data_old", bus.ir_data, {1'b1, 12'b0, 19'd75000});
    bus.ir_command = 1'b0;
    wait_fall("coinc_fall_lat");
    check_read("coinc_new_avg", {1'b1, 12'b0, 19'd75250});

    // Reset while responding; held command is re-serviced afterwards
    bus.ir_command = 1'b1;
    repeat (4) tick();
    check("respond_before_rst", bus.ir_response, 1);
    reset = 1'b1;
    tick();
    check("rst_respond_resp", bus.ir_response, 0);
    check("rst_respond_data", bus.ir_data, 0);
    check("rst_respond_flag", line_detected, 0);
    reset = 1'b0;
    begin
      int lat;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (bus.ir_response === 1'b1) begin
          lat = i;
          break;
        end
      end
      check("reservice_lat", lat, 4);
      check("reservice_data", bus.ir_data, 0);
    end
    bus.ir_command = 1'b0;
    wait_fall("reservice_fall_lat");

    // clock_valid low: reset, command and new input must all be ignored
    for (int i = 0; i < 4; i++) next_sample(19'd2500);
    check("pre_gate_flag", line_detected, 1);
    clock_valid    = 1'b0;
    ir_count       = 19'd0;
    reset          = 1'b1;
    bus.ir_command = 1'b1;
    repeat (40) tick();
    check("gated_flag", line_detected, 1);
    check("gated_response", bus.ir_response, 0);
    bus.ir_command = 1'b0;
    reset          = 1'b0;
    clock_valid    = 1'b1;
    check_read("gated_avg", {1'b1, 12'b0, 19'd2500});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
